// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction buffer between IF and ID.
// Keeps the valid/allowin handshake on both sides; a flush empties the queue in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_bus,
    output logic                       in_allowin,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_bus,
    input  logic                       out_allowin,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // Handshake qualifiers; everything here depends on count only, so no allowin-to-allowin path.
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
        push_c  = in_valid & ~full_c & ~flush;
        pop_c   = ~empty_c & out_allowin & ~flush;
    end

    // Pointer and occupancy next-state; flush overrides any same-cycle push or pop.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                wp_d = wp_q + PTR_W'(1);
            end
            if (pop_c) begin
                rp_d = rp_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset discards every entry immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; deliberately unreset, validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wp_q] <= in_bus;
        end
    end

    // Output decode from registered state plus the head-entry read.
    always_comb begin
        in_allowin  = ~full_c;
        out_valid   = ~empty_c;
        out_bus     = empty_c ? '0 : mem_q[rp_q];
        count       = count_q;
        almost_full = (count_q >= CNT_W'(AFULL_LVL));
    end

endmodule
